uart_frac_baud_gen: RTL

Programmable baud/oversample tick generator for the UART peripheral. It produces a fractional-N oversample tick, a TX bit tick and a mid-bit RX sample strobe. The divisor can be reloaded at runtime, and RX phase can be realigned on start-bit detection. It sits between the register interface and the UART TX/RX engines, and supersedes the fixed-divisor generator.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_frac_baud_gen_if.sv | 25 ++
 rtl/frac_tick_divider.sv | 57 +++++
 rtl/uart_frac_baud_gen.sv | 83 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and divisor helpers. TX/RX engines and the baud
// generator all use these, so every block agrees on oversampling and rounding.
package uart_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_FRAC_W     = 4;

    // Integer clocks per oversample tick.
    function automatic longint calc_div_int(input longint clk_freq, input longint baud,
                                            input longint os);
        return clk_freq / (baud * os);
    endfunction

    // Fractional remainder of the same ratio, in 1/2^frac_w cycle units.
    function automatic longint calc_div_frac(input longint clk_freq, input longint baud,
                                             input longint os, input int frac_w);
        longint scaled;
        scaled = (clk_freq << frac_w) / (baud * os);
        return scaled % (longint'(1) << frac_w);
    endfunction

endpackage

// File: rtl/uart_frac_baud_gen_if.sv
// Control and tick bundle between the UART register block (master) and the
// baud generator (slave).
interface uart_frac_baud_gen_if #(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
);
    logic              en;
    logic              cfg_load;
    logic [INT_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              rx_restart;
    logic              os_tick;
    logic              tx_tick;
    logic              rx_sample;

    modport master (
        output en, cfg_load, cfg_div_int, cfg_div_frac, rx_restart,
        input  os_tick, tx_tick, rx_sample
    );

    modport slave (
        input  en, cfg_load, cfg_div_int, cfg_div_frac, rx_restart,
        output os_tick, tx_tick, rx_sample
    );
endinterface

// File: rtl/frac_tick_divider.sv
// Fractional-N base divider: period alternates between div_int and div_int+1
// so the average is div_int + div_frac/2^FRAC_W clocks.
module frac_tick_divider #(
    parameter int                INT_W    = 16,
    parameter int                FRAC_W   = 4,
    parameter logic [INT_W-1:0]  DEF_INT  = 1,
    parameter logic [FRAC_W-1:0] DEF_FRAC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [INT_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              tick
);

    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [INT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [INT_W-1:0]  div_eff;
    logic [FRAC_W:0]   acc_sum;
    logic [INT_W:0]    last;

    // last = value of cnt on the final cycle of the current period (P_k - 1).
    always_comb begin
        div_eff = (div_int == '0) ? INT_W'(1) : div_int;
        acc_sum = {1'b0, acc} + {1'b0, div_frac};
        last    = {1'b0, div_eff} + (INT_W+1)'(acc_sum[FRAC_W]) - (INT_W+1)'(1);
        tick    = en && !cfg_load && ({1'b0, cnt} == last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_int  <= DEF_INT;
            div_frac <= DEF_FRAC;
            cnt      <= '0;
            acc      <= '0;
        end else begin
            if (cfg_load) begin
                div_int  <= cfg_div_int;
                div_frac <= cfg_div_frac;
            end
            if (!en || cfg_load) begin
                cnt <= '0;
                acc <= '0;
            end else if (tick) begin
                cnt <= '0;
                acc <= acc_sum[FRAC_W-1:0];
            end else begin
                cnt <= cnt + INT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// UART baud generator: oversample tick, TX bit tick and a mid-bit RX sample
// strobe whose phase can be realigned on start-bit detect.
module uart_frac_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int INT_W      = 16,
    parameter int FRAC_W     = DEF_FRAC_W
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frac_baud_gen_if.slave  bus
);

    localparam int                PH_W     = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   RX_MID   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [INT_W-1:0]  DEF_INT  =
        INT_W'(calc_div_int(longint'(CLK_FREQ), longint'(BAUD_RATE), longint'(OVERSAMPLE)));
    localparam logic [FRAC_W-1:0] DEF_FRAC =
        FRAC_W'(calc_div_frac(longint'(CLK_FREQ), longint'(BAUD_RATE), longint'(OVERSAMPLE), FRAC_W));

    logic            tick;
    logic [PH_W-1:0] tx_cnt;
    logic [PH_W-1:0] rx_cnt;
    logic            os_q, tx_q, rx_q;

    function automatic logic [PH_W-1:0] ph_inc(input logic [PH_W-1:0] p);
        return (p == PH_LAST) ? '0 : p + PH_W'(1);
    endfunction

    frac_tick_divider #(
        .INT_W   (INT_W),
        .FRAC_W  (FRAC_W),
        .DEF_INT (DEF_INT),
        .DEF_FRAC(DEF_FRAC)
    ) u_div (
        .clk         (clk),
        .reset       (reset),
        .en          (bus.en),
        .cfg_load    (bus.cfg_load),
        .cfg_div_int (bus.cfg_div_int),
        .cfg_div_frac(bus.cfg_div_frac),
        .tick        (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
            os_q   <= 1'b0;
            tx_q   <= 1'b0;
            rx_q   <= 1'b0;
        end else if (!bus.en || bus.cfg_load) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
            os_q   <= 1'b0;
            tx_q   <= 1'b0;
            rx_q   <= 1'b0;
        end else begin
            os_q <= tick;
            tx_q <= tick && (tx_cnt == PH_LAST);
            if (tick)
                tx_cnt <= ph_inc(tx_cnt);
            // A restart swallows a coincident tick so the new bit starts clean.
            if (bus.rx_restart) begin
                rx_cnt <= '0;
                rx_q   <= 1'b0;
            end else begin
                rx_q <= tick && (rx_cnt == RX_MID);
                if (tick)
                    rx_cnt <= ph_inc(rx_cnt);
            end
        end
    end

    assign bus.os_tick   = os_q;
    assign bus.tx_tick   = tx_q;
    assign bus.rx_sample = rx_q;

endmodule
